biquad8_pole_coeff_loader: RTL and testbench

- Sits directly upstream of the 8-sample biquad pole IIR stage and drives its serial coefficient port (coeff_dat / coeff_wr / coeff_update).
- Holds a shadow bank of NCOEFF 18-bit coefficients written over a simple register-style interface.
- On commit, snapshots the bank and shifts it into the IIR's 4-deep DSP B-cascade. It writes the tail DSP first, then pulses update so all DSPs switch coefficients in the same cycle.

---
 rtl/biquad8_pole_coeff_loader.sv | 146 ++++++++++++++
 tb/tb_biquad8_pole_coeff_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/biquad8_pole_coeff_loader.sv
// Shadow coefficient bank and serial loader for the 8-sample biquad pole IIR.
// Shifts a snapshot down the DSP B-cascade tail-first, then pulses update.
module biquad8_pole_coeff_loader #(
  parameter int NCOEFF     = 4,
  parameter int ADDR_BITS  = 2,
  parameter int COEFF_BITS = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_wr_i,
  input  logic [ADDR_BITS-1:0]  cfg_addr_i,
  input  logic [COEFF_BITS-1:0] cfg_dat_i,
  input  logic                  commit_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [COEFF_BITS-1:0] coeff_dat_o,
  output logic                  coeff_wr_o,
  output logic                  coeff_update_o
);

  localparam int IW = (NCOEFF > 1) ? $clog2(NCOEFF) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCOEFF - 1);
  localparam logic [ADDR_BITS:0] NC = (ADDR_BITS + 1)'(NCOEFF);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    UPDATE,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [COEFF_BITS-1:0] shadow     [NCOEFF];
  logic [COEFF_BITS-1:0] shadow_nxt [NCOEFF];
  logic [COEFF_BITS-1:0] work       [NCOEFF];
  logic [COEFF_BITS-1:0] work_nxt   [NCOEFF];

  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_nxt;
  logic                  pending;
  logic                  pending_nxt;
  logic                  busy_nxt;
  logic                  done_nxt;
  logic                  wr_nxt;
  logic                  upd_nxt;
  logic [COEFF_BITS-1:0] dat_nxt;
  logic                  wr_hit;

  assign wr_hit = cfg_wr_i && ({1'b0, cfg_addr_i} < NC);

  // Snapshot sees a write made in the same cycle.
  always_comb begin
    for (int i = 0; i < NCOEFF; i++) begin
      shadow_nxt[i] = shadow[i];
    end
    if (wr_hit) begin
      shadow_nxt[cfg_addr_i] = cfg_dat_i;
    end
  end

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    pending_nxt = pending;
    busy_nxt    = 1'b0;
    done_nxt    = 1'b0;
    wr_nxt      = 1'b0;
    upd_nxt     = 1'b0;
    dat_nxt     = coeff_dat_o;
    for (int i = 0; i < NCOEFF; i++) begin
      work_nxt[i] = work[i];
    end
    unique case (state)
      IDLE: begin
        if (commit_i || pending) begin
          for (int i = 0; i < NCOEFF; i++) begin
            work_nxt[i] = shadow_nxt[i];
          end
          pending_nxt = 1'b0;
          idx_nxt     = LAST;
          state_nxt   = SHIFT;
          busy_nxt    = 1'b1;
          wr_nxt      = 1'b1;
          dat_nxt     = shadow_nxt[NCOEFF-1];
        end
      end
      SHIFT: begin
        pending_nxt = pending | commit_i;
        busy_nxt    = 1'b1;
        if (idx != '0) begin
          idx_nxt = idx - IW'(1);
          wr_nxt  = 1'b1;
          dat_nxt = work[idx_nxt];
        end else begin
          state_nxt = UPDATE;
          upd_nxt   = 1'b1;
        end
      end
      UPDATE: begin
        pending_nxt = pending | commit_i;
        state_nxt   = DONE;
        done_nxt    = 1'b1;
      end
      DONE: begin
        pending_nxt = pending | commit_i;
        state_nxt   = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= '0;
      pending        <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      coeff_wr_o     <= 1'b0;
      coeff_update_o <= 1'b0;
      coeff_dat_o    <= '0;
      for (int i = 0; i < NCOEFF; i++) begin
        shadow[i] <= '0;
        work[i]   <= '0;
      end
    end else begin
      state          <= state_nxt;
      idx            <= idx_nxt;
      pending        <= pending_nxt;
      busy_o         <= busy_nxt;
      done_o         <= done_nxt;
      coeff_wr_o     <= wr_nxt;
      coeff_update_o <= upd_nxt;
      coeff_dat_o    <= dat_nxt;
      for (int i = 0; i < NCOEFF; i++) begin
        shadow[i] <= shadow_nxt[i];
        work[i]   <= work_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_biquad8_pole_coeff_loader.sv
// Randomized bench for biquad8_pole_coeff_loader against a
// timeline model of load sequences plus a small B1/B2 cascade model.
module tb_biquad8_pole_coeff_loader;

  localparam int N = 4;

  logic        clk;
  logic        rst_n;
  logic        cfg_wr_i;
  logic [1:0]  cfg_addr_i;
  logic [17:0] cfg_dat_i;
  logic        commit_i;
  logic        busy_o;
  logic        done_o;
  logic [17:0] coeff_dat_o;
  logic        coeff_wr_o;
  logic        coeff_update_o;

  biquad8_pole_coeff_loader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_wr_i       (cfg_wr_i),
    .cfg_addr_i     (cfg_addr_i),
    .cfg_dat_i      (cfg_dat_i),
    .commit_i       (commit_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .coeff_dat_o    (coeff_dat_o),
    .coeff_wr_o     (coeff_wr_o),
    .coeff_update_o (coeff_update_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  // Model: a load is a timeline anchored at the edge where it starts.
  logic [17:0] m_shadow [N];
  logic [17:0] m_snap   [N];
  logic [17:0] sh       [N];
  logic [17:0] m_prev;
  logic        m_active;
  logic        m_pend;
  int          m_start;
  logic        m_idle;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_shadow[i] = '0;
      m_active = 1'b0;
      m_pend   = 1'b0;
      m_prev   = '0;
    end else begin
      for (int i = 0; i < N; i++) sh[i] = m_shadow[i];
      if (cfg_wr_i && int'(cfg_addr_i) < N) sh[cfg_addr_i] = cfg_dat_i;
      m_idle = !m_active || (cyc - m_start >= N + 3);
      if (m_idle && (commit_i || m_pend)) begin
        if (m_active) m_prev = m_snap[0];
        for (int i = 0; i < N; i++) m_snap[i] = sh[i];
        m_start  = cyc;
        m_active = 1'b1;
        m_pend   = 1'b0;
      end else if (!m_idle && commit_i) begin
        m_pend = 1'b1;
      end
      for (int i = 0; i < N; i++) m_shadow[i] = sh[i];
    end
  end

  always @(negedge clk) begin
    int k;
    logic e_wr, e_upd, e_done, e_busy;
    logic [17:0] e_dat;
    if (cyc > 0) begin
      k      = cyc - m_start;
      e_wr   = m_active && k >= 0 && k < N;
      e_upd  = m_active && k == N;
      e_done = m_active && k == N + 1;
      e_busy = m_active && k >= 0 && k <= N;
      if (!m_active)  e_dat = m_prev;
      else if (k < N) e_dat = m_snap[N-1-k];
      else            e_dat = m_snap[0];
      chk("wr", 32'(coeff_wr_o), 32'(e_wr));
      chk("update", 32'(coeff_update_o), 32'(e_upd));
      chk("done", 32'(done_o), 32'(e_done));
      chk("busy", 32'(busy_o), 32'(e_busy));
      chk("dat", 32'(coeff_dat_o), 32'(e_dat));
    end
  end

  // IIR cascade: new word enters dsp0 and moves toward dsp3.
  logic [17:0] b1 [N];
  logic [17:0] b2 [N];
  initial for (int i = 0; i < N; i++) begin
    b1[i] = '0;
    b2[i] = '0;
  end
  always @(posedge clk) begin
    if (coeff_wr_o) begin
      b1[0] <= coeff_dat_o;
      for (int i = 1; i < N; i++) b1[i] <= b1[i-1];
    end
    if (coeff_update_o)
      for (int i = 0; i < N; i++) b2[i] <= b1[i];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_sh(input logic [1:0] a, input logic [17:0] d);
    cfg_wr_i   = 1'b1;
    cfg_addr_i = a;
    cfg_dat_i  = d;
    tick();
    cfg_wr_i = 1'b0;
  endtask

  task automatic pulse_commit(output int t);
    commit_i = 1'b1;
    tick();
    commit_i = 1'b0;
    t = cyc;
  endtask

  task automatic load_plan();
    wr_sh(2'd0, 18'h00011);
    wr_sh(2'd1, 18'h3FFFE);
    wr_sh(2'd2, 18'h12345);
    wr_sh(2'd3, 18'h20000);
  endtask

  int t;
  int done_cnt;

  initial begin
    rst_n      = 1'b0;
    cfg_wr_i   = 1'b0;
    cfg_addr_i = '0;
    cfg_dat_i  = '0;
    commit_i   = 1'b0;
    repeat (3) tick();
    chk("rst_dat", 32'(coeff_dat_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    rst_n = 1'b1;
    tick();

    load_plan();
    pulse_commit(t);
    chk("s1_w3", 32'(coeff_dat_o), 32'h20000);
    chk("s1_wr", 32'(coeff_wr_o), 32'h1);
    tick();
    chk("s1_w2", 32'(coeff_dat_o), 32'h12345);
    tick();
    chk("s1_w1", 32'(coeff_dat_o), 32'h3FFFE);
    tick();
    chk("s1_w0", 32'(coeff_dat_o), 32'h00011);
    tick();
    chk("s1_upd", 32'(coeff_update_o), 32'h1);
    chk("s1_upd_busy", 32'(busy_o), 32'h1);
    tick();
    chk("s1_done", 32'(done_o), 32'h1);
    chk("s1_done_busy", 32'(busy_o), 32'h0);
    chk("s1_b2_0", 32'(b2[0]), 32'h00011);
    chk("s1_b2_1", 32'(b2[1]), 32'h3FFFE);
    chk("s1_b2_2", 32'(b2[2]), 32'h12345);
    chk("s1_b2_3", 32'(b2[3]), 32'h20000);
    repeat (2) tick();

    pulse_commit(t);
    wr_sh(2'd1, 18'h00005);
    tick();
    chk("s3_old", 32'(coeff_dat_o), 32'h3FFFE);
    repeat (5) tick();
    pulse_commit(t);
    repeat (2) tick();
    chk("s3_new", 32'(coeff_dat_o), 32'h00005);
    repeat (5) tick();

    pulse_commit(t);
    tick();
    commit_i = 1'b1;
    repeat (2) tick();
    commit_i = 1'b0;
    done_cnt = 0;
    while (cyc < t + 22) begin
      tick();
      if (done_o) done_cnt++;
      if (cyc == t + 6) chk("s4_gap", 32'(coeff_wr_o), 32'h0);
      if (cyc == t + 7) chk("s4_restart", 32'(coeff_wr_o), 32'h1);
    end
    chk("s4_dones", 32'(done_cnt), 32'd2);

    cfg_wr_i   = 1'b1;
    cfg_addr_i = 2'd2;
    cfg_dat_i  = 18'h0ABCD;
    pulse_commit(t);
    cfg_wr_i = 1'b0;
    tick();
    chk("s5_same", 32'(coeff_dat_o), 32'h0ABCD);
    repeat (6) tick();

    pulse_commit(t);
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    chk("s6_wr", 32'(coeff_wr_o), 32'h0);
    chk("s6_dat", 32'(coeff_dat_o), 32'h0);
    chk("s6_busy", 32'(busy_o), 32'h0);
    rst_n = 1'b1;
    repeat (8) tick();
    chk("s6_noupd", 32'(b2[2]), 32'h0ABCD);
    load_plan();
    pulse_commit(t);
    chk("s6_w3", 32'(coeff_dat_o), 32'h20000);
    repeat (6) tick();
    chk("s6_b2_0", 32'(b2[0]), 32'h00011);
    chk("s6_b2_3", 32'(b2[3]), 32'h20000);

    for (int i = 0; i < 1500; i++) begin
      rst_n      = ($urandom_range(0, 249) != 0);
      cfg_wr_i   = ($urandom_range(0, 2) == 0);
      cfg_addr_i = 2'($urandom);
      cfg_dat_i  = 18'($urandom);
      commit_i   = ($urandom_range(0, 7) == 0);
      tick();
    end
    rst_n    = 1'b1;
    cfg_wr_i = 1'b0;
    commit_i = 1'b0;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
